// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared types and constants for the BIST response compactor
// Purpose: state encoding for the BIST session FSM and the default MISR geometry.
// Ports: none (package).
package bist_pkg;

    localparam int MISR_WIDTH = 9;

    // x^9 + x^4 + 1: only the x^4 term is an internal tap; bit 0 always takes the feedback.
    localparam logic [MISR_WIDTH-1:0] MISR_TAPS = 9'h010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } bist_state_t;

endpackage

// File: rtl/bist_misr_ctrl_if.sv
// rtl/bist_misr_ctrl_if.sv - control/response bundle between BIST sequencer and compactor
// Purpose: groups session control, the CUT response beat and the status/result outputs.
// Ports (master drives): start, resp_valid, resp
//       (slave drives):  pat_en, busy, done, pass, signature, pat_count
interface bist_misr_ctrl_if
    import bist_pkg::*;
#(
    parameter int WIDTH = MISR_WIDTH
);

    logic             start;
    logic             resp_valid;
    logic [WIDTH-1:0] resp;
    logic             pat_en;
    logic             busy;
    logic             done;
    logic             pass;
    logic [WIDTH-1:0] signature;
    logic [15:0]      pat_count;

    modport master (
        output start, resp_valid, resp,
        input  pat_en, busy, done, pass, signature, pat_count
    );

    modport slave (
        input  start, resp_valid, resp,
        output pat_en, busy, done, pass, signature, pat_count
    );

endinterface

// File: rtl/misr_core.sv
// rtl/misr_core.sv - multiple-input signature register with internal feedback taps
// Purpose: holds the signature and applies one compaction step per enabled cycle.
// Ports: clk, reset (async active-low), load (seed reload, wins over en), seed,
//        en (compact din this cycle), din (response word), sig (current signature).
module misr_core
    import bist_pkg::*;
#(
    parameter int               WIDTH   = MISR_WIDTH,
    parameter logic [WIDTH-1:0] TAPS    = MISR_TAPS,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sig
);

    logic             fb;
    logic [WIDTH-1:0] next_sig;

    // Rotate the MSB into bit 0, then fold it into the tapped positions above bit 0.
    always_comb begin
        fb       = sig[WIDTH-1];
        next_sig = {sig[WIDTH-2:0], fb} ^ din ^ ({TAPS[WIDTH-1:1], 1'b0} & {WIDTH{fb}});
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sig <= RST_VAL;
        end else if (load) begin
            sig <= seed;
        end else if (en) begin
            sig <= next_sig;
        end
    end

endmodule

// File: rtl/bist_misr_ctrl.sv
// rtl/bist_misr_ctrl.sv - BIST response compactor: session FSM, pattern counter, golden compare
// Purpose: gates the pattern generator, compacts CUT responses into the MISR, counts
//          accepted responses and reports pass/fail against GOLDEN at the end of a session.
// Ports: clk, reset (async active-low), bus (slave modport of bist_misr_ctrl_if):
//        start/resp_valid/resp in; pat_en/busy/done/pass/signature/pat_count out.
module bist_misr_ctrl
    import bist_pkg::*;
#(
    parameter int               WIDTH        = MISR_WIDTH,
    parameter logic [WIDTH-1:0] TAPS         = MISR_TAPS,
    parameter int               NUM_PATTERNS = 511,
    parameter logic [WIDTH-1:0] SEED         = '0,
    parameter logic [WIDTH-1:0] GOLDEN       = '0
) (
    input  logic             clk,
    input  logic             reset,
    bist_misr_ctrl_if.slave  bus
);

    localparam logic [15:0] LAST_COUNT = 16'(NUM_PATTERNS - 1);

    bist_state_t      state;
    logic [15:0]      pat_count;
    logic             pass;
    logic [WIDTH-1:0] sig;
    logic             launch;
    logic             accept;

    assign launch = bus.start && ((state == IDLE) || (state == DONE));
    assign accept = (state == RUN) && bus.resp_valid;

    misr_core #(
        .WIDTH   (WIDTH),
        .TAPS    (TAPS),
        .RST_VAL (SEED)
    ) u_misr (
        .clk   (clk),
        .reset (reset),
        .load  (launch),
        .seed  (SEED),
        .en    (accept),
        .din   (bus.resp),
        .sig   (sig)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            pat_count <= '0;
            pass      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state     <= RUN;
                        pat_count <= '0;
                    end
                end
                RUN: begin
                    if (bus.resp_valid) begin
                        pat_count <= pat_count + 16'd1;
                        if (pat_count == LAST_COUNT) begin
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    // The final beat landed in sig on the edge that entered CHECK.
                    pass  <= (sig == GOLDEN);
                    state <= DONE;
                end
                DONE: begin
                    if (bus.start) begin
                        state     <= RUN;
                        pat_count <= '0;
                        pass      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Decoded straight from the state register so the generator stops on the final-accept edge.
    assign bus.pat_en    = (state == RUN);
    assign bus.busy      = (state == RUN) || (state == CHECK);
    assign bus.done      = (state == DONE);
    assign bus.pass      = pass;
    assign bus.signature = sig;
    assign bus.pat_count = pat_count;

endmodule

// File: tb/tb_bist_misr_ctrl.sv
// tb/tb_bist_misr_ctrl.sv - self-checking bench for bist_misr_ctrl
module tb_bist_misr_ctrl;

    localparam int NI = 5;

    // Polynomial-division view of the MISR: shift, add the response, reduce by x^9+x^4+1.
    function automatic logic [8:0] misr_ref(input logic [8:0] s, input logic [8:0] r);
        int v;
        v = (int'(s) << 1) ^ int'(r);
        if ((v & 'h200) != 0) v = v ^ 'h211;
        return v[8:0];
    endfunction

    function automatic logic [8:0] gen_next(input logic [8:0] g);
        return {g[7:0], g[8] ^ g[4]};
    endfunction

    function automatic logic [8:0] full_sig();
        logic [8:0] s;
        logic [8:0] g;
        s = 9'h000;
        g = 9'h1FF;
        for (int k = 0; k < 511; k++) begin
            s = misr_ref(s, g);
            g = gen_next(g);
        end
        return s;
    endfunction

    localparam logic [8:0] FULL_SIG = full_sig();
    localparam int         NP_T   [NI] = '{7, 1, 2, 511, 511};
    localparam logic [8:0] SEED_T [NI] = '{9'h0A5, 9'h000, 9'h000, 9'h000, 9'h000};
    localparam logic [8:0] GOLD_T [NI] = '{9'h155, 9'h001, 9'h000, FULL_SIG, FULL_SIG ^ 9'h001};

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic       start_v [NI];
    logic       rv_v    [NI];
    logic [8:0] resp_v  [NI];
    logic       pe_o    [NI];
    logic       busy_o  [NI];
    logic       done_o  [NI];
    logic       pass_o  [NI];
    logic [8:0] sig_o   [NI];
    logic [15:0] cnt_o  [NI];

    for (genvar g = 0; g < NI; g++) begin : gi
        bist_misr_ctrl_if #(.WIDTH(9)) bus ();
        assign bus.start      = start_v[g];
        assign bus.resp_valid = rv_v[g];
        assign bus.resp       = resp_v[g];
        assign pe_o[g]   = bus.pat_en;
        assign busy_o[g] = bus.busy;
        assign done_o[g] = bus.done;
        assign pass_o[g] = bus.pass;
        assign sig_o[g]  = bus.signature;
        assign cnt_o[g]  = bus.pat_count;
        bist_misr_ctrl #(
            .NUM_PATTERNS (NP_T[g]),
            .SEED         (SEED_T[g]),
            .GOLDEN       (GOLD_T[g])
        ) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Session model: phase 0 idle, 1 collecting, 2 judging, 3 finished.
    int         m_ph   [NI];
    logic [8:0] m_sig  [NI];
    int         m_cnt  [NI];
    logic       m_pass [NI];

    always @(posedge clk or negedge reset) begin
        for (int i = 0; i < NI; i++) begin
            if (!reset) begin
                m_ph[i]   <= 0;
                m_sig[i]  <= SEED_T[i];
                m_cnt[i]  <= 0;
                m_pass[i] <= 1'b0;
            end else if ((m_ph[i] == 0 || m_ph[i] == 3) && start_v[i]) begin
                m_ph[i]   <= 1;
                m_sig[i]  <= SEED_T[i];
                m_cnt[i]  <= 0;
                m_pass[i] <= 1'b0;
            end else if (m_ph[i] == 1 && rv_v[i]) begin
                m_sig[i] <= misr_ref(m_sig[i], resp_v[i]);
                m_cnt[i] <= m_cnt[i] + 1;
                if (m_cnt[i] + 1 == NP_T[i]) m_ph[i] <= 2;
            end else if (m_ph[i] == 2) begin
                m_pass[i] <= (m_sig[i] == GOLD_T[i]);
                m_ph[i]   <= 3;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            logic [28:0] act;
            logic [28:0] exp;
            act = {pe_o[i], busy_o[i], done_o[i], pass_o[i], sig_o[i], cnt_o[i]};
            exp = {m_ph[i] == 1, m_ph[i] == 1 || m_ph[i] == 2, m_ph[i] == 3, m_pass[i],
                   m_sig[i], 16'(m_cnt[i])};
            n_tests = n_tests + 1;
            if (act !== exp) begin
                n_fail = n_fail + 1;
                $display("FAIL cycle_check inst%0d t=%0t got pe,busy,done,pass,sig,cnt=%b,%b,%b,%b,%h,%0d want %b,%b,%b,%b,%h,%0d",
                         i, $time, act[28], act[27], act[26], act[25], act[24:16], act[15:0],
                         exp[28], exp[27], exp[26], exp[25], exp[24:16], exp[15:0]);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int i);
        start_v[i] = 1'b1;
        tick();
        start_v[i] = 1'b0;
    endtask

    logic [8:0] gen;

    initial begin
        for (int i = 0; i < NI; i++) begin
            start_v[i] = 1'b0;
            rv_v[i]    = 1'b0;
            resp_v[i]  = 9'h000;
        end
        repeat (3) tick();
        @(negedge clk);
        check("reset_sig", 32'(sig_o[0]), 32'h0A5);
        check("reset_flags", {busy_o[0], done_o[0], pass_o[0], pe_o[0]}, 0);
        tick();
        reset = 1'b1;

        // Reset mid-session after three beats.
        pulse_start(0);
        rv_v[0] = 1'b1;
        repeat (3) begin
            resp_v[0] = 9'($urandom);
            tick();
        end
        rv_v[0] = 1'b0;
        @(negedge clk);
        check("three_beats_cnt", 32'(cnt_o[0]), 3);
        #2 reset = 1'b0;
        #1;
        check("abort_cnt", 32'(cnt_o[0]), 0);
        check("abort_sig", 32'(sig_o[0]), 32'h0A5);
        check("abort_flags", {busy_o[0], done_o[0], pass_o[0]}, 0);
        tick();
        reset = 1'b1;

        // Single-pattern session.
        pulse_start(1);
        rv_v[1] = 1'b1;
        resp_v[1] = 9'h001;
        tick();
        rv_v[1] = 1'b0;
        @(negedge clk);
        check("np1_sig", 32'(sig_o[1]), 32'h001);
        check("np1_check_phase", {busy_o[1], done_o[1]}, 32'b10);
        tick();
        @(negedge clk);
        check("np1_done_pass", {done_o[1], pass_o[1], busy_o[1]}, 32'b110);

        // Two patterns: feedback lands in bits 0 and 4.
        pulse_start(2);
        rv_v[2] = 1'b1;
        resp_v[2] = 9'h100;
        tick();
        @(negedge clk);
        check("np2_sig_a", 32'(sig_o[2]), 32'h100);
        #1 resp_v[2] = 9'h000;
        tick();
        rv_v[2] = 1'b0;
        @(negedge clk);
        check("np2_sig_b", 32'(sig_o[2]), 32'h011);

        // Gapped beats on instance 0.
        pulse_start(0);
        for (int k = 0; k < 9; k++) begin
            rv_v[0]   = (k % 3 == 0);
            resp_v[0] = 9'($urandom);
            tick();
        end
        rv_v[0] = 1'b0;
        @(negedge clk);
        check("gap_cnt", 32'(cnt_o[0]), 3);
        check("gap_pat_en", 32'(pe_o[0]), 1);

        // Randomised traffic, including starts while busy and start with resp_valid.
        for (int k = 0; k < 400; k++) begin
            #1;
            start_v[0] = ($urandom_range(0, 7) == 0);
            rv_v[0]    = 1'($urandom);
            resp_v[0]  = 9'($urandom);
            tick();
        end
        start_v[0] = 1'b0;

        // Drive instance 0 into DONE from whatever state it is in.
        pulse_start(0);
        rv_v[0] = 1'b1;
        repeat (10) begin
            resp_v[0] = 9'($urandom);
            tick();
        end
        rv_v[0] = 1'b0;
        @(negedge clk);
        check("settle_done", 32'(done_o[0]), 1);

        // start while busy is ignored.
        #1 pulse_start(0);
        rv_v[0] = 1'b1;
        resp_v[0] = 9'($urandom);
        tick();
        start_v[0] = 1'b1;
        resp_v[0] = 9'($urandom);
        tick();
        start_v[0] = 1'b0;
        rv_v[0] = 1'b0;
        @(negedge clk);
        check("busy_start_cnt", 32'(cnt_o[0]), 2);
        #1 rv_v[0] = 1'b1;
        repeat (8) begin
            resp_v[0] = 9'($urandom);
            tick();
        end
        rv_v[0] = 1'b0;
        @(negedge clk);
        check("done_before_restart", 32'(done_o[0]), 1);
        #1 start_v[0] = 1'b1;
        rv_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        rv_v[0] = 1'b0;
        @(negedge clk);
        check("restart_flags", {done_o[0], pass_o[0], busy_o[0]}, 32'b001);
        check("restart_sig", 32'(sig_o[0]), 32'h0A5);
        check("restart_cnt", 32'(cnt_o[0]), 0);

        // Full 511-beat session: identity CUT fed by the 9-bit generator.
        #1 start_v[3] = 1'b1;
        start_v[4] = 1'b1;
        tick();
        start_v[3] = 1'b0;
        start_v[4] = 1'b0;
        gen = 9'h1FF;
        rv_v[3] = 1'b1;
        rv_v[4] = 1'b1;
        for (int k = 0; k < 511; k++) begin
            resp_v[3] = gen;
            resp_v[4] = gen;
            tick();
            gen = gen_next(gen);
        end
        rv_v[3] = 1'b0;
        rv_v[4] = 1'b0;
        @(negedge clk);
        check("full_pat_en_off", 32'(pe_o[3]), 0);
        check("full_sig", 32'(sig_o[3]), 32'(FULL_SIG));
        check("full_cnt", 32'(cnt_o[3]), 511);
        tick();
        @(negedge clk);
        check("full_pass_golden", {done_o[3], pass_o[3]}, 32'b11);
        check("full_pass_flipped", {done_o[4], pass_o[4]}, 32'b10);

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
